// File: rtl/burst_ram_writer.sv
// burst_ram_writer
//   256 x 8 memory with two combinational read ports, filled by a burst-write
//   engine. The host pulses start_i with a start address and a beat count.
//   The engine then accepts one data beat per cycle over a valid/ready handshake,
//   writing at auto-incrementing addresses that wrap at the top of memory, and
//   pulses done_o once after the last beat.
//
// Optional feature (macro WRITE_CHECKSUM_EN):
//   Adds checksum_o, the running XOR of all beats in the current or last burst.
//
// Ports:
//   clk_i             rising-edge clock
//   rst_i             asynchronous reset, active-high
//   start_i           begin a burst (sampled only in idle)
//   start_address_i   first write address, latched on an accepted start
//   burst_length_i    beat count, latched on an accepted start (0 means 256)
//   write_data_i      data beat
//   write_valid_i     write_data_i is valid
//   write_ready_o     engine accepts a beat this cycle
//   busy_o            engine is not idle
//   done_o            one-cycle pulse after the last beat is written
//   read_address1_i   read port 1 address
//   read_address2_i   read port 2 address
//   value1_o          read port 1 data (combinational)
//   value2_o          read port 2 data (combinational)
//   checksum_o        XOR of burst beats (only with WRITE_CHECKSUM_EN)

module burst_ram_writer #(
    parameter int unsigned DataWidth    = 8,
    parameter int unsigned AddressWidth = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [AddressWidth-1:0] start_address_i,
    input  logic [AddressWidth-1:0] burst_length_i,
    input  logic [DataWidth-1:0]    write_data_i,
    input  logic                    write_valid_i,
    output logic                    write_ready_o,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic [AddressWidth-1:0] read_address1_i,
    input  logic [AddressWidth-1:0] read_address2_i,
    output logic [DataWidth-1:0]    value1_o,
`ifdef WRITE_CHECKSUM_EN
    output logic [DataWidth-1:0]    value2_o,
    output logic [DataWidth-1:0]    checksum_o
`else
    output logic [DataWidth-1:0]    value2_o
`endif
);

    localparam int unsigned Depth = 1 << AddressWidth;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    // One extra bit so a zero length can encode a full-memory burst.
    localparam logic [AddressWidth:0] FullBurst = {1'b1, {AddressWidth{1'b0}}};
    localparam logic [AddressWidth:0] LastBeat  = {{AddressWidth{1'b0}}, 1'b1};

    logic [1:0]              state_q, state_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [AddressWidth:0]   remaining_q, remaining_d;
    logic [DataWidth-1:0]    mem_q [Depth];
    logic                    transfer;
    logic                    start_accept;

    assign write_ready_o = (state_q == StWrite);
    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign transfer      = write_ready_o && write_valid_i;
    assign start_accept  = (state_q == StIdle) && start_i;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    addr_d      = start_address_i;
                    remaining_d = (burst_length_i == '0) ? FullBurst
                                                         : {1'b0, burst_length_i};
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                if (transfer) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LastBeat) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    // Storage is intentionally not reset; a reset mid-burst keeps beats already written.
    always_ff @(posedge clk_i) begin
        if (transfer) begin
            mem_q[addr_q] <= write_data_i;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write shows up next cycle.
    assign value1_o = mem_q[read_address1_i];
    assign value2_o = mem_q[read_address2_i];

`ifdef WRITE_CHECKSUM_EN
    logic [DataWidth-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_accept) begin
            checksum_d = '0;
        end else if (transfer) begin
            checksum_d = checksum_q ^ write_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum_o = checksum_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_burst_ram_writer.sv
module tb_burst_ram_writer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] start_address_i = '0;
    logic [7:0] burst_length_i = '0;
    logic [7:0] write_data_i = '0;
    logic       write_valid_i = 1'b0;
    logic       write_ready_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] read_address1_i = '0;
    logic [7:0] read_address2_i = '0;
    logic [7:0] value1_o;
    logic [7:0] value2_o;
`ifdef WRITE_CHECKSUM_EN
    logic [7:0] checksum_o;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk_i = ~clk_i;

    burst_ram_writer dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .start_address_i (start_address_i),
        .burst_length_i  (burst_length_i),
        .write_data_i    (write_data_i),
        .write_valid_i   (write_valid_i),
        .write_ready_o   (write_ready_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .read_address1_i (read_address1_i),
        .read_address2_i (read_address2_i),
        .value1_o        (value1_o),
`ifdef WRITE_CHECKSUM_EN
        .value2_o        (value2_o),
        .checksum_o      (checksum_o)
`else
        .value2_o        (value2_o)
`endif
    );

    // Drive-only helpers: no comparisons inside.
    task automatic begin_burst(input logic [7:0] addr, input logic [7:0] len);
        @(negedge clk_i);
        start_i         = 1'b1;
        start_address_i = addr;
        burst_length_i  = len;
        write_valid_i   = 1'b0;
        @(negedge clk_i);
        start_i         = 1'b0;
        start_address_i = 8'h00;
        burst_length_i  = 8'h00;
    endtask

    task automatic peek(input logic [7:0] addr, output logic [7:0] data);
        read_address1_i = addr;
        #1;
        data = value1_o;
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({write_ready_o, busy_o, done_o} !== 3'b000)
            $display("FAIL reset_outputs: got ready/busy/done=%b want 000",
                     {write_ready_o, busy_o, done_o});
        else passes++;
`ifdef WRITE_CHECKSUM_EN
        checks++;
        if (checksum_o !== 8'h00)
            $display("FAIL reset_checksum: got %h want 00", checksum_o);
        else passes++;
`endif
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy_o);
        else passes++;
    endtask

    task automatic test_basic;
        logic [7:0] beats [4];
        logic [7:0] rd;
        beats[0] = 8'hA1; beats[1] = 8'hB2; beats[2] = 8'hC3; beats[3] = 8'hD4;
        begin_burst(8'h10, 8'd4);
        // Cycle 1
        checks++;
        if ({busy_o, write_ready_o, done_o} !== 3'b110)
            $display("FAIL basic_cycle1: got busy/ready/done=%b want 110",
                     {busy_o, write_ready_o, done_o});
        else passes++;
        for (int k = 0; k < 4; k++) begin
            write_valid_i = 1'b1;
            write_data_i  = beats[k];
            @(negedge clk_i);
        end
        write_valid_i = 1'b0;
        // Cycle 5
        checks++;
        if ({busy_o, write_ready_o, done_o} !== 3'b101)
            $display("FAIL basic_cycle5: got busy/ready/done=%b want 101",
                     {busy_o, write_ready_o, done_o});
        else passes++;
`ifdef WRITE_CHECKSUM_EN
        checks++;
        if (checksum_o !== 8'h04) $display("FAIL basic_checksum: got %h want 04", checksum_o);
        else passes++;
`endif
        @(negedge clk_i);
        // Cycle 6
        checks++;
        if ({busy_o, done_o} !== 2'b00)
            $display("FAIL basic_cycle6: got busy/done=%b want 00", {busy_o, done_o});
        else passes++;
        for (int k = 0; k < 4; k++) begin
            peek(8'h10 + 8'(k), rd);
            checks++;
            if (rd !== beats[k])
                $display("FAIL basic_mem%0d: got %h want %h", k, rd, beats[k]);
            else passes++;
        end
    endtask

    task automatic test_wrap;
        logic [7:0] before01;
        logic [7:0] rd;
        peek(8'h01, before01);
        begin_burst(8'hFE, 8'd3);
        for (int k = 1; k <= 3; k++) begin
            write_valid_i = 1'b1;
            write_data_i  = 8'(k * 8'h11);
            @(negedge clk_i);
        end
        write_valid_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) $display("FAIL wrap_done: got %b want 1", done_o);
        else passes++;
`ifdef WRITE_CHECKSUM_EN
        checks++;
        if (checksum_o !== 8'h00) $display("FAIL wrap_checksum: got %h want 00", checksum_o);
        else passes++;
`endif
        @(negedge clk_i);
        peek(8'hFE, rd);
        checks++;
        if (rd !== 8'h11) $display("FAIL wrap_memFE: got %h want 11", rd); else passes++;
        peek(8'hFF, rd);
        checks++;
        if (rd !== 8'h22) $display("FAIL wrap_memFF: got %h want 22", rd); else passes++;
        peek(8'h00, rd);
        checks++;
        if (rd !== 8'h33) $display("FAIL wrap_mem00: got %h want 33", rd); else passes++;
        peek(8'h01, rd);
        checks++;
        if (rd !== before01) $display("FAIL wrap_mem01: got %h want %h", rd, before01);
        else passes++;
    endtask

    task automatic test_full_burst;
        int accepted = 0;
        int done_seen = 0;
        int bad = 0;
        logic finished = 1'b0;
        begin_burst(8'h00, 8'd0);
        for (int i = 0; i < 300 && !finished; i++) begin
            if (write_ready_o) begin
                write_valid_i = 1'b1;
                write_data_i  = 8'(accepted);
                accepted++;
            end else begin
                write_valid_i = 1'b0;
            end
            if (done_o) done_seen++;
            if (!busy_o) finished = 1'b1;
            else @(negedge clk_i);
        end
        write_valid_i = 1'b0;
        checks++;
        if (!finished) $display("FAIL full_timeout: got busy after 300 cycles want idle");
        else passes++;
        checks++;
        if (accepted != 256) $display("FAIL full_beats: got %0d want 256", accepted);
        else passes++;
        checks++;
        if (done_seen != 1) $display("FAIL full_done_count: got %0d want 1", done_seen);
        else passes++;
        for (int a = 0; a < 256; a++) begin
            read_address1_i = 8'(a);
            read_address2_i = 8'(a);
            #1;
            if (value1_o !== 8'(a) || value2_o !== 8'(a)) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL full_contents: got %0d bad addresses want 0", bad);
        else passes++;
`ifdef WRITE_CHECKSUM_EN
        checks++;
        if (checksum_o !== 8'h00) $display("FAIL full_checksum: got %h want 00", checksum_o);
        else passes++;
`endif
    endtask

    task automatic test_stall;
        logic [7:0] rd;
        begin_burst(8'h40, 8'd3);
        // Cycle 1: transfer
        write_valid_i = 1'b1; write_data_i = 8'h01;
        @(negedge clk_i);
        // Cycle 2: stall with junk data
        write_valid_i = 1'b0; write_data_i = 8'hEE;
        checks++;
        if (write_ready_o !== 1'b1) $display("FAIL stall_ready: got %b want 1", write_ready_o);
        else passes++;
        @(negedge clk_i);
        // Cycle 3: stall, plus a Start that must be ignored
        start_i = 1'b1; start_address_i = 8'h80; burst_length_i = 8'd1;
        @(negedge clk_i);
        start_i = 1'b0;
        // Cycles 4 and 5: transfers
        write_valid_i = 1'b1; write_data_i = 8'h02;
        @(negedge clk_i);
        write_data_i = 8'h03;
        checks++;
        if (done_o !== 1'b0) $display("FAIL stall_early_done: got %b want 0", done_o);
        else passes++;
        @(negedge clk_i);
        write_valid_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) $display("FAIL stall_done: got %b want 1", done_o);
        else passes++;
`ifdef WRITE_CHECKSUM_EN
        checks++;
        if (checksum_o !== 8'h00) $display("FAIL stall_checksum: got %h want 00", checksum_o);
        else passes++;
`endif
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) $display("FAIL stall_idle: got busy %b want 0", busy_o);
        else passes++;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) $display("FAIL stall_ignored_start: got busy %b want 0", busy_o);
        else passes++;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] want;
            want = (k < 3) ? 8'(k + 1) : 8'h43;
            peek(8'h40 + 8'(k), rd);
            checks++;
            if (rd !== want) $display("FAIL stall_mem%0d: got %h want %h", k, rd, want);
            else passes++;
        end
        peek(8'h80, rd);
        checks++;
        if (rd !== 8'h80) $display("FAIL stall_mem80: got %h want 80", rd); else passes++;
    endtask

    task automatic test_read_during_write;
        // Establish 0x00 at 0x20 first.
        begin_burst(8'h20, 8'd1);
        write_valid_i = 1'b1; write_data_i = 8'h00;
        @(negedge clk_i);
        write_valid_i = 1'b0;
        @(negedge clk_i);
        read_address1_i = 8'h20;
        read_address2_i = 8'h20;
        begin_burst(8'h20, 8'd1);
        write_valid_i = 1'b1; write_data_i = 8'h5A;
        #1;
        checks++;
        if (value1_o !== 8'h00 || value2_o !== 8'h00)
            $display("FAIL rdw_same_cycle: got %h/%h want 00/00", value1_o, value2_o);
        else passes++;
        @(negedge clk_i);
        write_valid_i = 1'b0;
        checks++;
        if (value1_o !== 8'h5A || value2_o !== 8'h5A)
            $display("FAIL rdw_next_cycle: got %h/%h want 5a/5a", value1_o, value2_o);
        else passes++;
        @(negedge clk_i);
    endtask

    task automatic test_reset_abort;
        logic [7:0] rd;
        int done_seen = 0;
        begin_burst(8'h90, 8'd4);
        write_valid_i = 1'b1; write_data_i = 8'hC0;
        @(negedge clk_i);
        write_data_i = 8'hC1;
        @(negedge clk_i);
        // Cycle 3: beat 3 offered, reset asserted before its edge.
        write_data_i = 8'hC2;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({busy_o, write_ready_o, done_o} !== 3'b000)
            $display("FAIL abort_outputs: got busy/ready/done=%b want 000",
                     {busy_o, write_ready_o, done_o});
        else passes++;
        @(negedge clk_i);
        write_valid_i = 1'b0;
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done_o) done_seen++;
            @(negedge clk_i);
        end
        checks++;
        if (done_seen != 0) $display("FAIL abort_done: got %0d pulses want 0", done_seen);
        else passes++;
`ifdef WRITE_CHECKSUM_EN
        checks++;
        if (checksum_o !== 8'h00) $display("FAIL abort_checksum: got %h want 00", checksum_o);
        else passes++;
`endif
        peek(8'h90, rd);
        checks++;
        if (rd !== 8'hC0) $display("FAIL abort_mem90: got %h want c0", rd); else passes++;
        peek(8'h91, rd);
        checks++;
        if (rd !== 8'hC1) $display("FAIL abort_mem91: got %h want c1", rd); else passes++;
        peek(8'h92, rd);
        checks++;
        if (rd !== 8'h92) $display("FAIL abort_mem92: got %h want 92", rd); else passes++;
        peek(8'h93, rd);
        checks++;
        if (rd !== 8'h93) $display("FAIL abort_mem93: got %h want 93", rd); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_full_burst();
        test_stall();
        test_read_during_write();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
